// File: rtl/torrence_types.sv
// Shared memory-hierarchy types: access size, operation and the main_memory FSM state,
// plus the lane helpers used to place sub-word accesses in a 32-bit word.
package torrence_types;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } operation_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } main_memory_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // First addressed lane once HALF/WORD addresses are aligned down.
  function automatic logic [1:0] lane_offset(input size_t size, input logic [1:0] addr_lo);
    case (size)
      BYTE:    return addr_lo;
      HALF:    return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input size_t size, input logic [1:0] offset);
    case (size)
      BYTE:    return 4'b0001 << offset;
      HALF:    return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/main_memory_array.sv
// Word-organised byte-lane RAM: per-lane write enable, registered read that holds
// its value until the next read enable, so it doubles as the load data register.
module main_memory_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 14
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [3:0]        we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i[l]) begin
        mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory.sv
// Bottom-of-hierarchy backing store with fixed programmable read/write latency, one response per request.
// Optional MAIN_MEMORY_BOUNDS_CHECK_EN adds req_fault for out-of-range or misaligned accesses.
module main_memory
  import torrence_types::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MEM_BYTES     = 65536,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_operation,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_store_word,
  output logic            req_fulfilled,
  output logic [XLEN-1:0] req_loaded_word
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
  ,
  output logic            req_fault
`endif
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned IDX_W = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned CNT_W = $clog2(max_u(READ_LATENCY, WRITE_LATENCY)) + 1;

  main_memory_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  operation_t         op_q;
  size_t              size_q;
  logic [1:0]         off_q;
  logic               fault_q;

  operation_t         req_op;
  size_t              req_sz;
  logic [1:0]         req_off;
  logic [3:0]         req_be;
  logic               accept;
  logic               fault_d;
  logic [CNT_W-1:0]   lat_m1;
  logic [XLEN-1:0]    masked_addr;
  logic [IDX_W-1:0]   word_idx;
  logic [3:0]         arr_we;
  logic               arr_re;
  logic [XLEN-1:0]    arr_wdata;
  logic [XLEN-1:0]    arr_rdata;
  logic [XLEN-1:0]    rd_shifted;
  logic [XLEN-1:0]    load_word;

  assign req_op      = operation_t'(req_operation);
  assign req_sz      = size_t'(req_size);
  assign req_off     = lane_offset(req_sz, req_addr[1:0]);
  assign req_be      = lane_mask(req_sz, req_off);
  assign accept      = !reset && (state_q == IDLE) && req_valid;
  assign lat_m1      = (req_op == STORE) ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
  assign masked_addr = req_addr & XLEN'(MEM_BYTES - 1);
  assign word_idx    = IDX_W'(masked_addr >> 2);

`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
  logic out_of_range;
  logic misaligned;

  assign out_of_range = {1'b0, req_addr} >= (XLEN + 1)'(MEM_BYTES);
  assign misaligned   = ((req_sz == HALF) && req_addr[0]) ||
                        ((req_sz != BYTE) && (req_sz != HALF) && (req_addr[1:0] != 2'b00));
  assign fault_d      = out_of_range || misaligned;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (accept && fault_d) begin
      $error("main_memory: faulting access addr=%h size=%0d op=%0d",
             req_addr, req_size, req_operation);
    end
  end
`endif
`else
  assign fault_d = 1'b0;
`endif

  // Stores commit and loads sample the array on the acceptance edge.
  assign arr_we    = (accept && (req_op == STORE) && !fault_d) ? req_be : 4'b0000;
  assign arr_re    = accept && (req_op == LOAD) && !fault_d;
  assign arr_wdata = req_store_word << {req_off, 3'b000};

  main_memory_array #(
    .DATA_W (XLEN),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .addr_i  (word_idx),
    .we_i    (arr_we),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = lat_m1;
          state_d = (lat_m1 == '0) ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= LOAD;
      size_q  <= BYTE;
      off_q   <= 2'b00;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= req_op;
        size_q  <= req_sz;
        off_q   <= req_off;
        fault_q <= fault_d;
      end
    end
  end

  always_comb begin
    rd_shifted = arr_rdata >> {off_q, 3'b000};
    case (size_q)
      BYTE:    load_word = {{(XLEN-8){1'b0}}, rd_shifted[7:0]};
      HALF:    load_word = {{(XLEN-16){1'b0}}, rd_shifted[15:0]};
      default: load_word = rd_shifted;
    endcase
  end

  always_comb begin
    req_fulfilled   = 1'b0;
    req_loaded_word = '0;
    if (state_q == RESPOND) begin
      req_fulfilled = 1'b1;
      if ((op_q == LOAD) && !fault_q) begin
        req_loaded_word = load_word;
      end
    end
  end

`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
  assign req_fault = (state_q == RESPOND) && fault_q;
`endif

endmodule

// File: doc/main_memory.md
# main_memory

Backing-store block on the far side of the L2 cache: it serves L2 line-fill and write-back traffic arriving on the hmem request channel. It holds a byte-addressable array and enforces a programmable fixed access latency. It returns one response per accepted request over a valid/fulfilled handshake. Used as the bottom of the memory hierarchy in simulation and FPGA builds.

## Interface
- XLEN, 32, data and address width
- MEM_BYTES, 65536, array size in bytes; power of two, ≥ 4
- READ_LATENCY, 4, cycles from load acceptance to response; ≥ 1
- WRITE_LATENCY, 2, cycles from store acceptance to response; ≥ 1

Ports:
- clk  in  1  sole clock; all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present; fields stable while high and unfulfilled
- req_operation  in  1  LOAD=0, STORE=1
- req_size  in  2  BYTE, HALF, WORD (torrence_types size enum)
- req_addr  in  XLEN  byte address
- req_store_word  in  XLEN  store data, right-aligned
- req_fulfilled  out  1  one-cycle response strobe
- req_loaded_word  out  XLEN  load data, zero-extended, valid with req_fulfilled
- req_fault  out  1  exists only with MAIN_MEMORY_BOUNDS_CHECK_EN

## Operation
- States: IDLE, BUSY, RESPOND.
- IDLE:
  - On req_valid, accept the request.
  - Load counter with latency−1 (READ_LATENCY or WRITE_LATENCY per op).
  - Go to BUSY, or directly to RESPOND when the latency is 1.
- Store commits to the array at the acceptance edge, on byte lanes selected by req_size and addr[1:0]:
  - BYTE: 1 lane.
  - HALF: 2 lanes.
  - WORD: 4 lanes.
- Load reads the array at the acceptance edge into a data register. Result is right-shifted by addr offset, masked to size, zero-extended.
- BUSY: decrement counter; at 0 go to RESPOND.
- RESPOND: req_fulfilled=1 for exactly this cycle; next state IDLE.
- Responses to stores drive req_loaded_word=0.
- Requests are not accepted in BUSY or RESPOND. req_valid seen there is ignored, with no queuing.
- Address handling without the macro:
  - Index = addr mod MEM_BYTES.
  - Misaligned HALF/WORD addresses are aligned down.
- Array contents are not touched by reset. Sim initial value is 0.

## Timing
- Reset values: req_fulfilled=0, req_loaded_word=0, req_fault=0, state IDLE, counter 0.
- Acceptance in cycle t (IDLE, req_valid=1) → req_fulfilled high in cycle t+LATENCY.
- Back-to-back: requester may hold req_valid high with new fields in cycle t+LATENCY+1. That request is accepted in that cycle, so there is one IDLE cycle between bursts.
- Requester must drop or change req_valid/fields no later than the cycle after req_fulfilled. A still-high req_valid is treated as a new request.
- Load issued right after a store to the same address returns the stored data, because the store has already committed.
- Reset mid-operation:
  - Return to IDLE and abandon the pending response (no fulfilled pulse).
  - A store accepted before reset stays committed.
- Counter width: clog2(max(READ_LATENCY, WRITE_LATENCY))+1 bits; no wrap.

## Configuration
- MAIN_MEMORY_BOUNDS_CHECK_EN defined:
  - req_fault port exists.
  - A request with addr ≥ MEM_BYTES, or misaligned (HALF at odd address, WORD with addr[1:0]≠0), is accepted and responds with normal latency.
  - Faulting requests: no array write, req_loaded_word=0, req_fault=1 in the same cycle as req_fulfilled.
  - Simulation-only $error on fault.
- Undefined: no req_fault port; modulo wrap and align-down behaviour as above.

## Structure
- torrence_types holds:
  - Existing size enum (BYTE/HALF/WORD) and LOAD/STORE operation enum.
  - New main_memory_state_t {IDLE, BUSY, RESPOND}.
- Sub-module main_memory_array: byte-lane RAM with 4-bit write-enable and registered word read. Inferable as block RAM; the top holds the FSM, counter and lane alignment.

## Test plan
- Reset held 3 cycles with req_valid=1 → no fulfilled, all outputs 0; first request accepted the cycle after reset drops.
- STORE WORD 0xDEADBEEF @0x100, then LOAD WORD @0x100 → fulfilled at t+2 for the store and t+4 for the load, data 0xDEADBEEF.
- STORE BYTE 0xAA @0x101 over 0x11223344, then LOAD WORD → 0x1122AA44; LOAD HALF @0x102 → 0x00001122.
- Back-to-back loads with req_valid held high → exactly one fulfilled per request, spaced READ_LATENCY+1 cycles.
- Reset asserted in BUSY of a LOAD → no fulfilled pulse; the next request behaves normally.
- With MAIN_MEMORY_BOUNDS_CHECK_EN: LOAD WORD @0x102 and STORE @MEM_BYTES → fault=1 with fulfilled, data 0, array unchanged. Without the macro, STORE @MEM_BYTES+4 aliases address 4.
